serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 22 ++
 rtl/full_subtractor_1bit.sv | 26 ++
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module   : serial_arith_pkg
// Purpose  : Shared definitions for the bit-serial arithmetic blocks: the
//            controller state encoding and the default operand width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor_1bit.sv
// ============================================================================
// Module   : full_subtractor_1bit
// Purpose  : Single-bit full subtractor cell computing a - b - bin.
// Ports    : a    in  1  minuend bit
//            b    in  1  subtrahend bit
//            bin  in  1  borrow in
//            d    out 1  difference bit
//            bout out 1  borrow out
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor. On an accepted start the operands are
//            captured and processed LSB-first, one bit per clock, through a
//            single full-subtractor cell. After WIDTH bit-cycles the result
//            and final borrow are registered onto Z/Bout and done pulses.
// Ports    : clk   in  1      clock, rising edge
//            rst   in  1      asynchronous active-high reset
//            start in  1      begin request, honoured in IDLE or DONE
//            A     in  WIDTH  minuend
//            B     in  WIDTH  subtrahend
//            Bin   in  1      borrow in
//            Z     out WIDTH  (A - B - Bin) mod 2^WIDTH, registered
//            Bout  out 1      borrow out, registered
//            busy  out 1      high in RUN
//            done  out 1      one-cycle pulse in DONE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Z,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_bit;
    logic               bit_d;
    logic               bit_bout;

    // Start is only looked at when no operation is in flight.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (cnt == LAST_BIT);

    full_subtractor_1bit u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            Z      <= '0;
            Bout   <= 1'b0;
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            br     <= Bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            // Difference bits enter at the MSB so that after WIDTH shifts
            // the first (LSB) bit has arrived at position 0.
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {bit_d, res_sh[WIDTH-1:1]};
            br     <= bit_bout;
            cnt    <= cnt + CNT_ONE;
            // Outputs are only updated on the final bit so they keep the
            // previous result for the whole of the next operation.
            if (last_bit) begin
                Z    <= {bit_d, res_sh[WIDTH-1:1]};
                Bout <= bit_bout;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic [W-1:0] Z;
    logic         Bout;
    logic         busy;
    logic         done;

    int tests;
    int fails;
    int done_cnt;
    int issued;

    logic [W:0]   exp_q[$];
    logic [W-1:0] last_z;
    logic         last_b;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Z     (Z),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("Z", int'(Z), int'(e[W:1]));
                check("Bout", int'(Bout), int'(e[0]));
                last_z = e[W:1];
                last_b = e[0];
            end
        end
    end

    // Issue one operation starting just after a negedge; returns at the
    // negedge where done is seen so a following call is back-to-back.
    // inj > 0 pulses start with other operands at that RUN cycle.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bin, input int inj);
        int   diff;
        logic [W:0] e;
        bit   seen;
        diff = int'(a) - int'(b) - int'(bin);
        e[W:1] = W'(diff & ((1 << W) - 1));
        e[0]   = (int'(a) < int'(b) + int'(bin));
        exp_q.push_back(e);
        issued++;
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs after capture; result must not change.
        A = ~a; B = ~b; Bin = ~bin;
        check("busy_after_accept", int'(busy), 1);
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == inj) begin
                start = 1'b1; A = b; B = a; Bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
                check("latency", i, W + 1);
                break;
            end
            check("busy_in_run", int'(busy), 1);
            check("Z_hold", int'(Z), int'(last_z));
            check("Bout_hold", int'(Bout), int'(last_b));
        end
        start = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no done expected done within 40 cycles at %0t", $time);
        end
    endtask

    initial begin
        tests = 0; fails = 0; done_cnt = 0; issued = 0;
        last_z = '0; last_b = 1'b0;
        start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        rst = 1'b1;
        #1;
        check("reset_Z", int'(Z), 0);
        check("reset_Bout", int'(Bout), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero operands
        op(4'b0000, 4'b0000, 1'b0, 0);
        @(negedge clk);
        check("idle_after_done", int'(busy) + int'(done), 0);

        // Back-to-back pair from DONE
        op(4'b1000, 4'b0111, 1'b0, 0);
        op(4'b1000, 4'b0111, 1'b1, 0);
        @(negedge clk);

        // Borrow-out cases
        op(4'b0111, 4'b1000, 1'b0, 0);
        op(4'b0000, 4'b0000, 1'b1, 0);
        @(negedge clk);

        // Start pulsed during RUN cycle 2 must be ignored
        op(4'b1100, 4'b0101, 1'b0, 2);
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in RUN cycle 2
        A = 4'b1010; B = 4'b0011; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        last_z = '0; last_b = 1'b0;
        #1;
        check("abort_Z", int'(Z), 0);
        check("abort_Bout", int'(Bout), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        // Start held high across an edge while reset is asserted
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_in_reset", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (8) @(negedge clk);
        op(4'b1111, 4'b0001, 1'b0, 0);
        @(negedge clk);

        // Exhaustive sweep, back-to-back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op(W'(a), W'(b), c[0], 0);

        repeat (4) @(negedge clk);
        check("done_count", done_cnt, issued);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
